// File: rtl/aib_avmm_pkg.sv
// Shared AVMM arbitration definitions.
// Holds the arbiter state encoding, the substitute read data returned on a
// read-response timeout, and the default AVMM bus widths used by the
// calibration FSMs.
package aib_avmm_pkg;

  localparam int unsigned AVMM_ADDR_W = 17;
  localparam int unsigned AVMM_DATA_W = 32;

  localparam logic [31:0] RD_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RDATA
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Searches req_i starting at last_grant_i+1 (modulo NUM_REQ) and returns the
// first active requester.
//   req_i        : request vector
//   last_grant_i : index of the previously granted requester
//   gnt_oh_o     : one-hot grant (all zero when nothing requests)
//   gnt_idx_o    : index of the granted requester
//   any_req_o    : at least one request is active
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
  output logic [NUM_REQ-1:0]         gnt_oh_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       any_req_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    // i = NUM_REQ wraps back to last_grant itself, which has lowest priority
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_grant_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        gnt_oh_o[cand] = 1'b1;
        gnt_idx_o      = cand;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/aib_avmm_arbiter.sv
// Per-transaction round-robin arbiter sharing one AIB PHY AVMM port between
// several sequencing masters. The grant is held until a write is accepted or
// read data returns; a read that never sees readdatavalid is terminated after
// RD_TIMEOUT cycles with substitute data and a sticky error flag.
//   req_*_i / req_*_o : packed per-requester AVMM slave-side ports
//   avmm_*_o / avmm_*_i : master-side AVMM port to the PHY
//   grant_o           : current or last granted requester index
//   busy_o            : arbiter is not idle
//   rd_timeout_err_o  : sticky read-timeout flag, cleared only by reset
module aib_avmm_arbiter
  import aib_avmm_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_W     = AVMM_ADDR_W,
  parameter int unsigned DATA_W     = AVMM_DATA_W,
  parameter int unsigned RD_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_write_i,
  input  logic [NUM_REQ-1:0]           req_read_i,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_address_i,
  input  logic [NUM_REQ*DATA_W-1:0]    req_writedata_i,
  input  logic [NUM_REQ*4-1:0]         req_byteenable_i,
  output logic [NUM_REQ-1:0]           req_waitrequest_o,
  output logic [DATA_W-1:0]            req_readdata_o,
  output logic [NUM_REQ-1:0]           req_readdatavalid_o,
  output logic                         avmm_write_o,
  output logic                         avmm_read_o,
  output logic [ADDR_W-1:0]            avmm_address_o,
  output logic [DATA_W-1:0]            avmm_writedata_o,
  output logic [3:0]                   avmm_byteenable_o,
  input  logic                         avmm_waitrequest_i,
  input  logic [DATA_W-1:0]            avmm_readdata_i,
  input  logic                         avmm_readdatavalid_i,
  output logic [$clog2(NUM_REQ)-1:0]   grant_o,
  output logic                         busy_o,
  output logic                         rd_timeout_err_o
);

  localparam int unsigned     GNT_W    = $clog2(NUM_REQ);
  localparam int unsigned     CNT_W    = $clog2(RD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  arb_state_t         state_q, state_d;
  logic [GNT_W-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
  logic [GNT_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [GNT_W-1:0]   pick_idx;
  logic               any_req;

  logic               g_write, g_read;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_wdata;
  logic [3:0]         g_be;
  logic               timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i        (req_write_i | req_read_i),
    .last_grant_i (last_grant_q),
    .gnt_oh_o     (pick_oh),
    .gnt_idx_o    (pick_idx),
    .any_req_o    (any_req)
  );

  assign g_write = req_write_i[grant_q];
  assign g_read  = req_read_i[grant_q];
  assign g_addr  = req_address_i[grant_q*ADDR_W +: ADDR_W];
  assign g_wdata = req_writedata_i[grant_q*DATA_W +: DATA_W];
  assign g_be    = req_byteenable_i[grant_q*4 +: 4];

  // A real readdatavalid in the final cycle takes precedence over the timeout
  assign timeout_hit = (state_q == WAIT_RDATA) && !avmm_readdatavalid_i &&
                       (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= GNT_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d      = pick_idx;
          grant_oh_d   = pick_oh;
          last_grant_d = pick_idx;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (!g_write && !g_read) begin
          state_d = IDLE;
        end else if (g_write) begin
          if (!avmm_waitrequest_i) state_d = IDLE;
        end else if (!avmm_waitrequest_i) begin
          state_d = WAIT_RDATA;
          cnt_d   = '0;
        end
      end
      WAIT_RDATA: begin
        if (avmm_readdatavalid_i) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    avmm_write_o        = 1'b0;
    avmm_read_o         = 1'b0;
    avmm_address_o      = '0;
    avmm_writedata_o    = '0;
    avmm_byteenable_o   = '0;
    req_waitrequest_o   = '1;
    req_readdatavalid_o = '0;
    req_readdata_o      = '0;
    case (state_q)
      ISSUE: begin
        avmm_write_o      = g_write;
        avmm_read_o       = g_read & ~g_write;
        avmm_address_o    = g_addr;
        avmm_writedata_o  = g_wdata;
        avmm_byteenable_o = g_be;
        req_waitrequest_o = ~(grant_oh_q & {NUM_REQ{~avmm_waitrequest_i}});
        req_readdata_o    = avmm_readdata_i;
      end
      WAIT_RDATA: begin
        req_readdata_o      = timeout_hit ? DATA_W'(RD_TIMEOUT_DATA) : avmm_readdata_i;
        req_readdatavalid_o = grant_oh_q &
                              {NUM_REQ{avmm_readdatavalid_i | timeout_hit}};
      end
      default: ;
    endcase
  end

  assign grant_o          = grant_q;
  assign busy_o           = (state_q != IDLE);
  assign rd_timeout_err_o = err_q;

endmodule

// File: tb/tb_aib_avmm_arbiter.sv
module tb_aib_avmm_arbiter;

  localparam int unsigned NUM_REQ    = 3;
  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RD_TIMEOUT = 16;
  localparam int unsigned GW         = $clog2(NUM_REQ);

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_write_i;
  logic [NUM_REQ-1:0]        req_read_i;
  logic [NUM_REQ*ADDR_W-1:0] req_address_i;
  logic [NUM_REQ*DATA_W-1:0] req_writedata_i;
  logic [NUM_REQ*4-1:0]      req_byteenable_i;
  logic [NUM_REQ-1:0]        req_waitrequest_o;
  logic [DATA_W-1:0]         req_readdata_o;
  logic [NUM_REQ-1:0]        req_readdatavalid_o;
  logic                      avmm_write_o;
  logic                      avmm_read_o;
  logic [ADDR_W-1:0]         avmm_address_o;
  logic [DATA_W-1:0]         avmm_writedata_o;
  logic [3:0]                avmm_byteenable_o;
  logic                      avmm_waitrequest_i;
  logic [DATA_W-1:0]         avmm_readdata_i;
  logic                      avmm_readdatavalid_i;
  logic [GW-1:0]             grant_o;
  logic                      busy_o;
  logic                      rd_timeout_err_o;

  typedef struct {
    int unsigned       req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [3:0]        be;
  } cmd_t;

  typedef struct {
    int unsigned       req;
    logic [DATA_W-1:0] data;
  } rsp_t;

  cmd_t exp_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;

  aib_avmm_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_write_i          (req_write_i),
    .req_read_i           (req_read_i),
    .req_address_i        (req_address_i),
    .req_writedata_i      (req_writedata_i),
    .req_byteenable_i     (req_byteenable_i),
    .req_waitrequest_o    (req_waitrequest_o),
    .req_readdata_o       (req_readdata_o),
    .req_readdatavalid_o  (req_readdatavalid_o),
    .avmm_write_o         (avmm_write_o),
    .avmm_read_o          (avmm_read_o),
    .avmm_address_o       (avmm_address_o),
    .avmm_writedata_o     (avmm_writedata_o),
    .avmm_byteenable_o    (avmm_byteenable_o),
    .avmm_waitrequest_i   (avmm_waitrequest_i),
    .avmm_readdata_i      (avmm_readdata_i),
    .avmm_readdatavalid_i (avmm_readdatavalid_i),
    .grant_o              (grant_o),
    .busy_o               (busy_o),
    .rd_timeout_err_o     (rd_timeout_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_req(input int unsigned r, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [3:0] be);
    req_write_i[r] = wr;
    req_read_i[r]  = ~wr;
    req_address_i[r*ADDR_W +: ADDR_W]   = a;
    req_writedata_i[r*DATA_W +: DATA_W] = d;
    req_byteenable_i[r*4 +: 4]          = be;
  endtask

  task automatic clear_reqs();
    req_write_i = '0;
    req_read_i  = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_reqs();
    avmm_waitrequest_i   = 1'b0;
    avmm_readdatavalid_i = 1'b0;
    avmm_readdata_i      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for the master to present a command; ends on a negedge.
  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (avmm_write_o || avmm_read_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({avmm_write_o, avmm_read_o, avmm_address_o, avmm_writedata_o, avmm_byteenable_o} !== '0) begin
      errors++;
      $display("FAIL reset_master: got w=%b r=%b a=%h d=%h be=%h, expected all 0",
               avmm_write_o, avmm_read_o, avmm_address_o, avmm_writedata_o, avmm_byteenable_o);
    end
    checks++;
    if ({req_waitrequest_o, req_readdatavalid_o, req_readdata_o} !== {3'b111, 3'b000, 32'h0}) begin
      errors++;
      $display("FAIL reset_slave: got wreq=%b rdv=%b rdata=%h, expected 111 000 0",
               req_waitrequest_o, req_readdatavalid_o, req_readdata_o);
    end
    checks++;
    if ({grant_o, busy_o, rd_timeout_err_o} !== {2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_status: got grant=%0d busy=%b err=%b, expected 0 0 0",
               grant_o, busy_o, rd_timeout_err_o);
    end
    apply_reset();
  endtask

  task automatic test_single_write();
    cmd_t e;
    @(posedge clk); #1;
    avmm_waitrequest_i = 1'b0;
    set_req(0, 1'b1, 17'h0208, 32'h1234_5678, 4'hF);
    exp_q.push_back('{0, 17'h0208, 32'h1234_5678, 4'hF});
    @(negedge clk);
    checks++;
    if ({req_waitrequest_o[0], avmm_write_o} !== 2'b10) begin
      errors++;
      $display("FAIL sw_latency: got wreq0=%b write=%b, expected 1 0", req_waitrequest_o[0], avmm_write_o);
    end
    @(negedge clk);
    checks++;
    if ({avmm_write_o, avmm_read_o, req_waitrequest_o} !== {1'b1, 1'b0, 3'b110}) begin
      errors++;
      $display("FAIL sw_issue: got write=%b read=%b wreq=%b, expected 1 0 110",
               avmm_write_o, avmm_read_o, req_waitrequest_o);
    end
    e = exp_q.pop_front();
    checks++;
    if ({grant_o, avmm_address_o, avmm_writedata_o, avmm_byteenable_o} !== {GW'(e.req), e.addr, e.data, e.be}) begin
      errors++;
      $display("FAIL sw_data: got g=%0d a=%h d=%h be=%h, expected g=%0d a=%h d=%h be=%h",
               grant_o, avmm_address_o, avmm_writedata_o, avmm_byteenable_o, e.req, e.addr, e.data, e.be);
    end
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL sw_idle: got busy=%b, expected 0", busy_o);
    end
  endtask

  task automatic test_round_robin();
    cmd_t        e;
    int unsigned seq [NUM_REQ];
    int          done;
    int          last_c;
    int unsigned g;
    apply_reset();
    @(posedge clk); #1;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      seq[r] = 0;
      set_req(r, 1'b1, ADDR_W'(17'h0100 + r), 32'hC0DE_0000 | (r << 8), 4'hF);
    end
    for (int unsigned k = 0; k < 6; k++)
      exp_q.push_back('{k % 3, ADDR_W'(17'h0100 + k % 3), 32'hC0DE_0000 | ((k % 3) << 8) | (k / 3), 4'hF});
    done   = 0;
    last_c = 0;
    for (int c = 0; c < 60 && done < 6; c++) begin
      @(negedge clk);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (i != int'(grant_o)) begin
          checks++;
          if (req_waitrequest_o[i] !== 1'b1) begin
            errors++;
            $display("FAIL rr_wreq_other: req %0d got %b, expected 1 (grant %0d)", i, req_waitrequest_o[i], grant_o);
          end
        end
      end
      if (avmm_write_o && !avmm_waitrequest_i) begin
        e = exp_q.pop_front();
        checks++;
        if ({grant_o, avmm_address_o, avmm_writedata_o} !== {GW'(e.req), e.addr, e.data}) begin
          errors++;
          $display("FAIL rr_order: got g=%0d a=%h d=%h, expected g=%0d a=%h d=%h",
                   grant_o, avmm_address_o, avmm_writedata_o, e.req, e.addr, e.data);
        end
        if (done > 0) begin
          checks++;
          if (c - last_c != 2) begin
            errors++;
            $display("FAIL rr_spacing: got %0d cycles between grants, expected 2", c - last_c);
          end
        end
        last_c = c;
        g      = int'(grant_o);
        done++;
        @(posedge clk); #1;
        seq[g]++;
        req_writedata_i[g*DATA_W +: DATA_W] = 32'hC0DE_0000 | (g << 8) | seq[g];
        if (done == 6) clear_reqs();
      end
    end
    checks++;
    if (done != 6) begin
      errors++;
      $display("FAIL rr_count: got %0d completions, expected 6", done);
    end
    exp_q.delete();
    clear_reqs();
  endtask

  task automatic test_backpressure();
    cmd_t e;
    bit   ok;
    @(posedge clk); #1;
    avmm_waitrequest_i = 1'b1;
    set_req(1, 1'b1, 17'h0ABC, 32'hBEEF_0001, 4'h3);
    exp_q.push_back('{1, 17'h0ABC, 32'hBEEF_0001, 4'h3});
    wait_cmd(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_issue: got no command within 20 cycles, expected write");
      exp_q.delete();
    end else begin
      for (int c = 0; c < 6; c++) begin
        if (c > 0) @(negedge clk);
        checks++;
        if ({avmm_write_o, grant_o, avmm_address_o} !== {1'b1, 2'd1, 17'h0ABC}) begin
          errors++;
          $display("FAIL bp_stable: cycle %0d got w=%b g=%0d a=%h, expected 1 1 0abc",
                   c, avmm_write_o, grant_o, avmm_address_o);
        end
        checks++;
        if (req_waitrequest_o !== ((c < 5) ? 3'b111 : 3'b101)) begin
          errors++;
          $display("FAIL bp_wreq: cycle %0d got %b, expected %b", c, req_waitrequest_o, (c < 5) ? 3'b111 : 3'b101);
        end
        if (c == 5) begin
          e = exp_q.pop_front();
          checks++;
          if ({avmm_writedata_o, avmm_byteenable_o} !== {e.data, e.be}) begin
            errors++;
            $display("FAIL bp_data: got d=%h be=%h, expected d=%h be=%h",
                     avmm_writedata_o, avmm_byteenable_o, e.data, e.be);
          end
        end
        @(posedge clk); #1;
        if (c == 4) avmm_waitrequest_i = 1'b0;
        if (c == 5) clear_reqs();
      end
    end
    clear_reqs();
    avmm_waitrequest_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({avmm_write_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL bp_done: got write=%b busy=%b, expected 0 0", avmm_write_o, busy_o);
    end
  endtask

  task automatic test_read();
    rsp_t e;
    bit   got;
    @(posedge clk); #1;
    avmm_waitrequest_i   = 1'b0;
    avmm_readdatavalid_i = 1'b1;
    avmm_readdata_i      = 32'h1111_2222;
    set_req(2, 1'b0, 17'h0300, 32'h0, 4'hF);
    rsp_q.push_back('{2, 32'hA5A5_0001});
    @(negedge clk);
    checks++;
    if (req_readdatavalid_o !== 3'b000) begin
      errors++;
      $display("FAIL rd_stray_idle: got rdv=%b, expected 000", req_readdatavalid_o);
    end
    @(negedge clk);
    checks++;
    if ({avmm_read_o, avmm_write_o, grant_o, avmm_address_o} !== {1'b1, 1'b0, 2'd2, 17'h0300}) begin
      errors++;
      $display("FAIL rd_issue: got r=%b w=%b g=%0d a=%h, expected 1 0 2 0300",
               avmm_read_o, avmm_write_o, grant_o, avmm_address_o);
    end
    checks++;
    if ({req_readdatavalid_o, req_waitrequest_o} !== {3'b000, 3'b011}) begin
      errors++;
      $display("FAIL rd_issue_flags: got rdv=%b wreq=%b, expected 000 011", req_readdatavalid_o, req_waitrequest_o);
    end
    @(posedge clk); #1;
    clear_reqs();
    got = 1'b0;
    for (int w = 1; w <= 20 && !got; w++) begin
      avmm_readdatavalid_i = (w == 3);
      avmm_readdata_i      = (w == 3) ? 32'hA5A5_0001 : 32'h0BAD_0000;
      @(negedge clk);
      if (w == 1) begin
        checks++;
        if ({avmm_write_o, avmm_read_o, req_waitrequest_o} !== {2'b00, 3'b111}) begin
          errors++;
          $display("FAIL rd_wait_master: got w=%b r=%b wreq=%b, expected 0 0 111",
                   avmm_write_o, avmm_read_o, req_waitrequest_o);
        end
      end
      if (req_readdatavalid_o != 3'b000) begin
        got = 1'b1;
        e   = rsp_q.pop_front();
        checks++;
        if ({req_readdatavalid_o, req_readdata_o} !== {3'(1 << e.req), e.data}) begin
          errors++;
          $display("FAIL rd_resp: got rdv=%b data=%h, expected rdv=%b data=%h",
                   req_readdatavalid_o, req_readdata_o, 3'(1 << e.req), e.data);
        end
        checks++;
        if (w != 3) begin
          errors++;
          $display("FAIL rd_latency: got response at wait cycle %0d, expected 3", w);
        end
      end
      @(posedge clk); #1;
    end
    avmm_readdatavalid_i = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rd_timeout_wait: got no readdatavalid in 20 cycles, expected one");
      rsp_q.delete();
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle: got busy=%b, expected 0", busy_o);
    end
  endtask

  task automatic test_timeout();
    rsp_t e;
    cmd_t c;
    bit   ok;
    bit   got;
    @(posedge clk); #1;
    avmm_waitrequest_i   = 1'b0;
    avmm_readdatavalid_i = 1'b0;
    avmm_readdata_i      = 32'h7777_7777;
    set_req(0, 1'b0, 17'h0040, 32'h0, 4'hF);
    rsp_q.push_back('{0, 32'hDEAD_BEEF});
    wait_cmd(ok);
    checks++;
    if (!(ok && avmm_read_o)) begin
      errors++;
      $display("FAIL to_issue: got ok=%b read=%b, expected 1 1", ok, avmm_read_o);
    end
    @(posedge clk); #1;
    clear_reqs();
    got = 1'b0;
    for (int w = 0; w < 40 && !got; w++) begin
      @(negedge clk);
      if (w == 0) begin
        checks++;
        if ({rd_timeout_err_o, busy_o} !== 2'b01) begin
          errors++;
          $display("FAIL to_pre: got err=%b busy=%b, expected 0 1", rd_timeout_err_o, busy_o);
        end
      end
      if (req_readdatavalid_o != 3'b000) begin
        got = 1'b1;
        e   = rsp_q.pop_front();
        checks++;
        if ({req_readdatavalid_o, req_readdata_o} !== {3'(1 << e.req), e.data}) begin
          errors++;
          $display("FAIL to_resp: got rdv=%b data=%h, expected rdv=%b data=%h",
                   req_readdatavalid_o, req_readdata_o, 3'(1 << e.req), e.data);
        end
        checks++;
        if (w != int'(RD_TIMEOUT) - 1) begin
          errors++;
          $display("FAIL to_latency: got pulse at wait cycle %0d, expected %0d", w, RD_TIMEOUT - 1);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL to_nopulse: got no timeout pulse in 40 cycles, expected one");
      rsp_q.delete();
    end
    @(negedge clk);
    checks++;
    if ({rd_timeout_err_o, busy_o, req_readdatavalid_o} !== {1'b1, 1'b0, 3'b000}) begin
      errors++;
      $display("FAIL to_after: got err=%b busy=%b rdv=%b, expected 1 0 000",
               rd_timeout_err_o, busy_o, req_readdatavalid_o);
    end
    @(posedge clk); #1;
    set_req(1, 1'b1, 17'h0555, 32'h600D_F00D, 4'hF);
    exp_q.push_back('{1, 17'h0555, 32'h600D_F00D, 4'hF});
    wait_cmd(ok);
    c = exp_q.pop_front();
    checks++;
    if ({ok, avmm_write_o, grant_o, avmm_address_o, avmm_writedata_o} !== {2'b11, GW'(c.req), c.addr, c.data}) begin
      errors++;
      $display("FAIL to_next: got ok=%b w=%b g=%0d a=%h d=%h, expected 1 1 %0d %h %h",
               ok, avmm_write_o, grant_o, avmm_address_o, avmm_writedata_o, c.req, c.addr, c.data);
    end
    checks++;
    if (rd_timeout_err_o !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: got err=%b, expected 1", rd_timeout_err_o);
    end
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    cmd_t e;
    bit   ok;
    @(posedge clk); #1;
    avmm_waitrequest_i = 1'b0;
    avmm_readdata_i    = 32'hFFFF_0000;
    set_req(1, 1'b0, 17'h0777, 32'h0, 4'hF);
    wait_cmd(ok);
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    checks++;
    if ({ok, busy_o, req_readdata_o} !== {2'b11, 32'hFFFF_0000}) begin
      errors++;
      $display("FAIL rst_pre: got ok=%b busy=%b rdata=%h, expected 1 1 ffff0000", ok, busy_o, req_readdata_o);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({avmm_write_o, avmm_read_o, avmm_address_o, avmm_writedata_o, avmm_byteenable_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid_master: got w=%b r=%b a=%h, expected 0 0 0", avmm_write_o, avmm_read_o, avmm_address_o);
    end
    checks++;
    if ({req_waitrequest_o, req_readdatavalid_o, req_readdata_o} !== {3'b111, 3'b000, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid_slave: got wreq=%b rdv=%b rdata=%h, expected 111 000 0",
               req_waitrequest_o, req_readdatavalid_o, req_readdata_o);
    end
    checks++;
    if ({grant_o, busy_o, rd_timeout_err_o} !== {2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_status: got grant=%0d busy=%b err=%b, expected 0 0 0",
               grant_o, busy_o, rd_timeout_err_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(0, 1'b1, 17'h0011, 32'h0000_0A0A, 4'h1);
    set_req(2, 1'b1, 17'h0022, 32'h0000_0C0C, 4'h8);
    exp_q.push_back('{0, 17'h0011, 32'h0000_0A0A, 4'h1});
    exp_q.push_back('{2, 17'h0022, 32'h0000_0C0C, 4'h8});
    for (int k = 0; k < 2; k++) begin
      wait_cmd(ok);
      e = exp_q.pop_front();
      checks++;
      if ({ok, avmm_write_o, grant_o, avmm_address_o, avmm_writedata_o, avmm_byteenable_o} !==
          {2'b11, GW'(e.req), e.addr, e.data, e.be}) begin
        errors++;
        $display("FAIL rst_first_grant: txn %0d got ok=%b w=%b g=%0d a=%h, expected 1 1 %0d %h",
                 k, ok, avmm_write_o, grant_o, avmm_address_o, e.req, e.addr);
      end
      @(posedge clk); #1;
      req_write_i[e.req] = 1'b0;
    end
    clear_reqs();
    @(negedge clk);
  endtask

  initial begin
    rst_n                = 1'b0;
    req_write_i          = '0;
    req_read_i           = '0;
    req_address_i        = '0;
    req_writedata_i      = '0;
    req_byteenable_i     = '0;
    avmm_waitrequest_i   = 1'b0;
    avmm_readdata_i      = '0;
    avmm_readdatavalid_i = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_backpressure();
    test_read();
    test_timeout();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aib_avmm_arbiter.md
# aib_avmm_arbiter

Shares the single AIB PHY AVMM configuration port between several sequencing masters: the static register-config FSM, the phase-adjust FSM, and a debug/CSR bridge. It sits between the calibration master and the PHY AVMM slave. It arbitrates per transaction with round-robin fairness and holds the grant until a write is accepted or read data returns. A read-response timeout keeps a silent slave from hanging calibration.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 17, AVMM address width
- DATA_W, 32, AVMM data width
- RD_TIMEOUT, 1024, cycles to wait for readdatavalid after read acceptance (≥2)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_write_i  in  NUM_REQ  per-requester write request
- req_read_i  in  NUM_REQ  per-requester read request
- req_address_i  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_writedata_i  in  NUM_REQ*DATA_W  packed write data
- req_byteenable_i  in  NUM_REQ*4  packed byte enables
- req_waitrequest_o  out  NUM_REQ  per-requester waitrequest
- req_readdata_o  out  DATA_W  read data, broadcast to all requesters
- req_readdatavalid_o  out  NUM_REQ  per-requester read-data valid
- avmm_write_o / avmm_read_o  out  1  master-side commands
- avmm_address_o  out  ADDR_W; avmm_writedata_o  out  DATA_W; avmm_byteenable_o  out  4
- avmm_waitrequest_i  in  1; avmm_readdata_i  in  DATA_W; avmm_readdatavalid_i  in  1
- grant_o  out  $clog2(NUM_REQ)  index of current or last grant
- busy_o  out  1  high in any state other than IDLE
- rd_timeout_err_o  out  1  sticky; set when a read times out, cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT_RDATA.
- IDLE:
  - Active set = req_write_i | req_read_i.
  - If the set is non-empty, select the first active index searching from last_grant+1 modulo NUM_REQ.
  - Register the selection into grant_o and last_grant, then go to ISSUE.
- ISSUE:
  - Master outputs mux the granted requester's write, read, address, writedata and byteenable.
  - req_waitrequest_o[g] = avmm_waitrequest_i. All other waitrequest bits stay 1.
  - If write is high and avmm_waitrequest_i is low, the write completes: go to IDLE.
  - Else if read is high and avmm_waitrequest_i is low, the read is accepted: go to WAIT_RDATA and clear the timeout counter.
  - If write and read are both high, the transaction is treated as a write; the read is ignored.
  - If the granted requester drops both write and read (illegal), go to IDLE with no master command that cycle.
- WAIT_RDATA:
  - Master write and read outputs are 0.
  - req_readdata_o = avmm_readdata_i.
  - req_readdatavalid_o[g] = avmm_readdatavalid_i. On valid, go to IDLE.
  - If the counter reaches RD_TIMEOUT-1 without valid:
    - pulse req_readdatavalid_o[g] for 1 cycle with req_readdata_o = 32'hDEAD_BEEF;
    - set rd_timeout_err_o;
    - go to IDLE.
- Outside ISSUE: all req_waitrequest_o = 1 and master outputs are 0.
- Reset values:
  - master write, read, address, writedata, byteenable = 0;
  - req_waitrequest_o all 1; req_readdatavalid_o all 0; req_readdata_o = 0;
  - grant_o = 0; last_grant = NUM_REQ-1, so requester 0 wins first; busy_o = 0; rd_timeout_err_o = 0; state = IDLE.
- Reset mid-transaction abandons it immediately. Outputs return to reset values asynchronously.

## Timing
- Arbitration latency: a request seen in IDLE at cycle N drives the master in cycle N+1. The requester therefore sees waitrequest = 1 for at least 1 cycle.
- Write with zero slave wait: 2 cycles from req to completion, then IDLE. A back-to-back next grant issues at N+3.
- Read: waitrequest, readdata and readdatavalid are combinational pass-through in ISSUE and WAIT_RDATA. There are no added response cycles.
- In the timeout case, the error readdatavalid is issued in the cycle the counter equals RD_TIMEOUT-1, and the state is IDLE on the next cycle.
- A readdatavalid arriving in IDLE or ISSUE (stray) is dropped; all req_readdatavalid_o stay 0.
- The timeout counter is $clog2(RD_TIMEOUT) bits wide and saturates. It counts only in WAIT_RDATA.

## Structure
- Package aib_avmm_pkg holds:
  - arb_state_t enum;
  - the RD_TIMEOUT_DATA = 32'hDEAD_BEEF constant;
  - the default ADDR_W and DATA_W localparams shared with the calibration FSMs.
- Sub-module rr_arbiter (NUM_REQ): purely combinational round-robin pick from a request vector and last_grant. It outputs a one-hot grant, an index and an any_req flag.

## Test plan
- Single write: req0 writes addr 17'h0208, data 32'h1234_5678, slave waitrequest low → master write at cycle 1 with those values; req_waitrequest_o[0] low that cycle; busy_o returns to 0.
- Round-robin: all 3 requesters write simultaneously and repeatedly → grant order 0,1,2,0; no requester starves; non-granted waitrequest stays 1 throughout.
- Slave backpressure: avmm_waitrequest_i held high 5 cycles during req1's write → master command and address stable for 6 cycles; grant does not move.
- Read: req2 reads, slave returns readdatavalid 3 cycles after acceptance with 32'hA5A5_0001 → only req_readdatavalid_o[2] pulses, with that data.
- Read timeout: RD_TIMEOUT=16, slave never responds → at cycle 15 after acceptance, req_readdatavalid_o[g] pulses with 32'hDEAD_BEEF; rd_timeout_err_o = 1 and sticky; the next request is still served.
- Reset mid-read: assert rst_n low in WAIT_RDATA → all outputs at reset values immediately; after release, req0 wins first arbitration.
